seq_accum_alu: RTL and testbench
================================

# seq_accum_alu

Parametrised, handshaked successor to the 16-bit project ALU. It adds configurable datapath width, a bank of NACC accumulator registers selectable as the A operand and as the write-back target, subtract and load ops, and a multi-cycle shift-add multiply. It sits between the operand-fetch stage and result write-back. Operands are accepted on a valid/ready handshake; results return as a one-cycle out_valid pulse.

## Interface
- WIDTH, 16: datapath width, ≥4.
- NACC, 4: accumulator count, power of 2, ≥2.
- AW, $clog2(NACC): accumulator select width (derived).
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; equals (state == IDLE).
- op  in  3  000 NOP, 001 ADD, 010 AND, 011 OR, 100 SLT, 101 SUB, 110 MUL, 111 LOAD.
- use_acc  in  1  1: A = ACC[acc_sel]; 0: A = X.
- wb  in  1  1: Results also written to ACC[acc_sel].
- acc_sel  in  AW  accumulator index.
- X, Y  in  WIDTH  operands; B = Y always.
- out_valid  out  1  one-cycle pulse, Results/CF/ZF valid.
- Results  out  WIDTH  registered result; holds between pulses.
- CF  out  1  carry/borrow/compare/overflow flag, registered.
- ZF  out  1  Results == 0, registered with Results.

## Operation
- Accept = in_valid & in_ready. All operands, op, use_acc, wb and acc_sel are sampled only on the accept edge. An in_valid with in_ready low is ignored and is not queued.
- NOP: accepted. No out_valid. Results, CF, ZF and the accumulators are unchanged.
- ADD: Results = (A+B)[WIDTH-1:0]; CF = carry out (bit WIDTH of the WIDTH+1-bit sum).
- SUB: Results = (A−B) mod 2^WIDTH; CF = borrow (A < B unsigned).
- AND / OR: bitwise; CF = 0.
- SLT: unsigned compare; Results = {0…0, A<B}; CF = A<B.
- LOAD: Results = B; CF = 0. Use with wb=1 to initialise an accumulator.
- MUL: unsigned A×B using a shift-add over WIDTH steps. Results = low WIDTH bits of the product; CF = 1 iff the high WIDTH bits of the product are nonzero.
- ZF is updated for every op that pulses out_valid.
- wb=1: ACC[acc_sel] ← Results on the same edge that registers Results. wb is ignored for NOP.
- FSM states:
  - IDLE: accept single-cycle ops, stay in IDLE; an accepted MUL loads the multiplicand, multiplier, partial product and step counter, then goes to MUL.
  - MUL: one shift-add step per cycle; after WIDTH steps, register the result and flags, pulse out_valid, return to IDLE.

## Timing
- Reset (RST high at an edge) sets state=IDLE, all ACC=0, Results=0, CF=0, ZF=0, out_valid=0. in_ready is 1 from the cycle after the reset edge. While RST is high, requests are not accepted.
- Single-cycle op accepted in cycle N: out_valid=1 in cycle N+1 with the new Results, CF and ZF.
- in_ready stays 1, so back-to-back issue runs at one op per cycle.
- MUL accepted in cycle N:
  - in_ready=0 for cycles N+1 … N+WIDTH.
  - out_valid=1 in cycle N+WIDTH+1, which is also when in_ready returns to 1.
- Accumulator forwarding: an op accepted in cycle N+1 with use_acc reading the ACC written by the op accepted in cycle N sees the new value. No stall is needed because the write lands at the end of cycle N.
- Reset during MUL: the multiply is aborted; no out_valid for it; accumulators are cleared.
- out_valid is never held for more than one cycle. There is no output back-pressure; the consumer must capture on the pulse.
- Arithmetic is unsigned throughout; every intermediate is WIDTH+1 bits (sum/diff) or 2·WIDTH bits (product).

## Test plan
- Reset, then ADD X=0xFFFF Y=0x0001 → next cycle out_valid=1, Results=0x0000, CF=1, ZF=1.
- LOAD Y=5 wb=1 acc_sel=1, then back-to-back ADD use_acc=1 acc_sel=1 Y=7 wb=1, then ADD use_acc=1 acc_sel=1 Y=3 → pulses Results=0x0005, 0x000C, 0x000F on consecutive cycles.
- SUB X=3 Y=5 → Results=0xFFFE, CF=1; SLT X=3 Y=5 → Results=0x0001, CF=1, ZF=0; SLT X=5 Y=3 → Results=0x0000, CF=0, ZF=1; NOP → no pulse, outputs held.
- MUL X=0x0100 Y=0x0100 with in_valid held high → in_ready=0 for 16 cycles, ignored requests produce nothing, out_valid 17 cycles after accept with Results=0x0000, CF=1, ZF=1. Then MUL 0x0003×0x0007 → Results=0x0015, CF=0.
- RST at the 5th MUL cycle → no out_valid; in_ready=1 after reset. Then ADD use_acc=1 acc_sel=1 Y=0 → Results=0, ZF=1, proving the accumulators were cleared.
- WIDTH=8, NACC=2 build: ADD 0xFF+0x01 → 0x00, CF=1; MUL 0x10×0x10 → 0x00, CF=1, out_valid 9 cycles after accept.

Source files
------------

// File: rtl/seq_accum_alu.sv
// Handshaked accumulator ALU: single-cycle ADD/SUB/AND/OR/SLT/LOAD plus a
// WIDTH-step shift-add multiply, with a bank of NACC write-back accumulators.
module seq_accum_alu #(
    parameter int WIDTH = 16,
    parameter int NACC  = 4,
    parameter int AW    = $clog2(NACC)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic             wb,
    input  logic [AW-1:0]    acc_sel,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    output logic [WIDTH-1:0] Results,
    output logic             CF,
    output logic             ZF
);

    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;
    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q [NACC];
    logic [WIDTH-1:0]   acc_d [NACC];
    logic [WIDTH-1:0]   results_q, results_d;
    logic               cf_q, cf_d, zf_q, zf_d, out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mwb_q, mwb_d;
    logic [AW-1:0]      msel_q, msel_d;

    logic               accept;
    logic [WIDTH-1:0]   a_opnd;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod_step;
    logic               res_en, res_cf, res_wb;
    logic [WIDTH-1:0]   res_val;
    logic [AW-1:0]      res_sel;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid & in_ready;
    // Combinational accumulator read gives back-to-back forwarding for free.
    assign a_opnd    = use_acc ? acc_q[acc_sel] : X;
    assign sum       = {1'b0, a_opnd} + {1'b0, Y};
    assign diff      = {1'b0, a_opnd} - {1'b0, Y};
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    assign out_valid = out_valid_q;
    assign Results   = results_q;
    assign CF        = cf_q;
    assign ZF        = zf_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        mwb_d    = mwb_q;
        msel_d   = msel_q;
        res_en   = 1'b0;
        res_val  = results_q;
        res_cf   = cf_q;
        res_wb   = 1'b0;
        res_sel  = acc_sel;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    res_wb = wb;
                    case (op)
                        OP_ADD:  begin res_en = 1'b1; res_val = sum[WIDTH-1:0];   res_cf = sum[WIDTH]; end
                        OP_SUB:  begin res_en = 1'b1; res_val = diff[WIDTH-1:0];  res_cf = diff[WIDTH]; end
                        OP_AND:  begin res_en = 1'b1; res_val = a_opnd & Y;       res_cf = 1'b0; end
                        OP_OR:   begin res_en = 1'b1; res_val = a_opnd | Y;       res_cf = 1'b0; end
                        OP_SLT:  begin
                            res_en  = 1'b1;
                            res_val = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
                            res_cf  = diff[WIDTH];
                        end
                        OP_LOAD: begin res_en = 1'b1; res_val = Y;                res_cf = 1'b0; end
                        OP_MUL:  begin
                            mcand_d  = {{WIDTH{1'b0}}, a_opnd};
                            mplier_d = Y;
                            prod_d   = '0;
                            cnt_d    = '0;
                            mwb_d    = wb;
                            msel_d   = acc_sel;
                            state_d  = MUL;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // The last step's sum goes straight to the result registers.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_en  = 1'b1;
                    res_val = prod_step[WIDTH-1:0];
                    res_cf  = |prod_step[2*WIDTH-1:WIDTH];
                    res_wb  = mwb_q;
                    res_sel = msel_q;
                    state_d = IDLE;
                end
            end
        endcase
        results_d   = res_val;
        cf_d        = res_cf;
        zf_d        = res_en ? (res_val == '0) : zf_q;
        out_valid_d = res_en;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NACC; gi++) begin : g_acc
            assign acc_d[gi] = (res_en && res_wb && (res_sel == AW'(gi))) ? res_val : acc_q[gi];
            always_ff @(posedge CLK) begin
                if (RST) acc_q[gi] <= '0;
                else     acc_q[gi] <= acc_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            results_q   <= '0;
            cf_q        <= 1'b0;
            zf_q        <= 1'b0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            mwb_q       <= 1'b0;
            msel_q      <= '0;
        end else begin
            state_q     <= state_d;
            results_q   <= results_d;
            cf_q        <= cf_d;
            zf_q        <= zf_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            mwb_q       <= mwb_d;
            msel_q      <= msel_d;
        end
    end

endmodule

// File: tb/tb_seq_accum_alu.sv
// Bench for seq_accum_alu: behavioural model checked every cycle, literal
// expectations from the test plan, random traffic, and a WIDTH=8 build.
module tb_seq_accum_alu;
    localparam int W = 16;
    localparam int N = 4;
    localparam int A_W = 2;
    localparam longint unsigned MASK = (64'd1 << W) - 1;
    localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           SLT = 3'd4, SUB = 3'd5, MUL = 3'd6, LOAD = 3'd7;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic in_valid = 1'b0, use_acc = 1'b0, wb = 1'b0;
    logic [2:0] op = 3'd0;
    logic [A_W-1:0] acc_sel = '0;
    logic [W-1:0] X = '0, Y = '0;
    logic in_ready, out_valid, CF, ZF;
    logic [W-1:0] Results;

    logic in_valid8 = 1'b0;
    logic [2:0] op8 = 3'd0;
    logic [7:0] X8 = '0, Y8 = '0;
    logic in_ready8, out_valid8, CF8, ZF8;
    logic [7:0] Results8;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    seq_accum_alu #(.WIDTH(W), .NACC(N)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .use_acc(use_acc), .wb(wb), .acc_sel(acc_sel), .X(X), .Y(Y),
        .out_valid(out_valid), .Results(Results), .CF(CF), .ZF(ZF));

    seq_accum_alu #(.WIDTH(8), .NACC(2)) dut8 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .use_acc(1'b0), .wb(1'b0), .acc_sel(1'b0), .X(X8), .Y(Y8),
        .out_valid(out_valid8), .Results(Results8), .CF(CF8), .ZF(ZF8));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: outputs as they must look after each rising edge.
    longint unsigned m_acc [N];
    longint unsigned m_res = 0, m_prod = 0;
    bit m_cf = 0, m_zf = 0, m_valid = 0, m_ready = 1, m_live = 0, m_mwb = 0;
    int m_left = 0, m_msel = 0;

    task automatic m_commit(input longint unsigned r, input bit c, input bit w, input int s);
        m_res = r & MASK;
        m_cf = c;
        m_zf = (m_res == 0);
        m_valid = 1;
        if (w) m_acc[s] = m_res;
    endtask

    always @(posedge CLK) begin
        longint unsigned a, b;
        m_valid = 0;
        if (RST) begin
            m_live = 1;
            foreach (m_acc[i]) m_acc[i] = 0;
            m_res = 0; m_cf = 0; m_zf = 0; m_ready = 1; m_left = 0;
        end else if (m_live) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_commit(m_prod, (m_prod >> W) != 0, m_mwb, m_msel);
                    m_ready = 1;
                end
            end else if (in_valid) begin
                a = use_acc ? m_acc[acc_sel] : longint'(X);
                b = longint'(Y);
                case (op)
                    ADD:  m_commit(a + b, (a + b) > MASK, wb, int'(acc_sel));
                    SUB:  m_commit(a - b, a < b, wb, int'(acc_sel));
                    AND_: m_commit(a & b, 0, wb, int'(acc_sel));
                    OR_:  m_commit(a | b, 0, wb, int'(acc_sel));
                    SLT:  m_commit((a < b) ? 1 : 0, a < b, wb, int'(acc_sel));
                    LOAD: m_commit(b, 0, wb, int'(acc_sel));
                    MUL: begin
                        m_prod = a * b; m_left = W; m_ready = 0;
                        m_mwb = wb; m_msel = int'(acc_sel);
                    end
                    default: ;
                endcase
            end
        end
    end

    typedef struct {string nm; logic [W-1:0] r; bit c; bit z;} lit_t;
    lit_t lq[$];

    task automatic push_lit(input string nm, input logic [W-1:0] r, input bit c, input bit z);
        lit_t l;
        l.nm = nm; l.r = r; l.c = c; l.z = z;
        lq.push_back(l);
    endtask

    always @(negedge CLK) begin
        lit_t l;
        if (m_live) begin
            chk("in_ready", in_ready, m_ready);
            chk("out_valid", out_valid, m_valid);
            chk("Results", Results, m_res);
            chk("CF", CF, m_cf);
            chk("ZF", ZF, m_zf);
            if (out_valid === 1'b1 && lq.size() > 0) begin
                l = lq.pop_front();
                chk({l.nm, "_res"}, Results, l.r);
                chk({l.nm, "_cf"}, CF, l.c);
                chk({l.nm, "_zf"}, ZF, l.z);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input bit ua, input bit w, input int s,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1; op = o; use_acc = ua; wb = w; acc_sel = s[A_W-1:0]; X = x; Y = y;
        @(posedge CLK); #1;
        in_valid = 0;
    endtask

    task automatic drain_lits();
        for (int i = 0; i < 60 && lq.size() > 0; i++) begin
            @(posedge CLK); #1;
        end
        tests++;
        if (lq.size() > 0) begin
            fails++;
            $display("FAIL lit_timeout: %0d expected pulses missing", lq.size());
            lq.delete();
        end
    endtask

    function automatic logic [W-1:0] rv();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return '1;
            2: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int k, rl;
        repeat (2) @(posedge CLK);
        #1 RST = 0;

        push_lit("add_carry", 16'h0000, 1, 1);
        issue(ADD, 0, 0, 0, 16'hFFFF, 16'h0001);
        drain_lits();

        push_lit("load5", 16'h0005, 0, 0);
        push_lit("acc_add7", 16'h000C, 0, 0);
        push_lit("acc_add3", 16'h000F, 0, 0);
        issue(LOAD, 0, 1, 1, 16'h0000, 16'h0005);
        issue(ADD, 1, 1, 1, 16'h0000, 16'h0007);
        issue(ADD, 1, 0, 1, 16'h0000, 16'h0003);
        drain_lits();

        push_lit("sub_borrow", 16'hFFFE, 1, 0);
        push_lit("slt_true", 16'h0001, 1, 0);
        push_lit("slt_false", 16'h0000, 0, 1);
        issue(SUB, 0, 0, 0, 16'd3, 16'd5);
        issue(SLT, 0, 0, 0, 16'd3, 16'd5);
        issue(SLT, 0, 0, 0, 16'd5, 16'd3);
        drain_lits();
        issue(NOP, 0, 1, 1, 16'h1234, 16'h5678);
        @(negedge CLK);
        chk("nop_no_pulse", out_valid, 0);
        chk("nop_held_res", Results, 16'h0000);
        chk("nop_held_zf", ZF, 1);
        @(posedge CLK); #1;

        // MUL with in_valid held high: requests during the busy window are dropped.
        push_lit("mul_ovf", 16'h0000, 1, 1);
        in_valid = 1; op = MUL; use_acc = 0; wb = 0; X = 16'h0100; Y = 16'h0100;
        @(posedge CLK); #1;
        op = ADD; X = 16'h0001; Y = 16'h0001;
        k = 0; rl = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (out_valid === 1'b1) begin k = i; break; end
            if (in_ready === 1'b0) rl++;
        end
        in_valid = 0;
        chk("mul_latency", k, 17);
        chk("mul_ready_low", rl, 16);
        @(posedge CLK); #1;
        drain_lits();
        push_lit("mul_3x7", 16'h0015, 0, 0);
        issue(MUL, 0, 0, 0, 16'h0003, 16'h0007);
        drain_lits();

        // Reset in the 5th MUL cycle aborts it and clears the accumulators.
        issue(MUL, 0, 1, 1, 16'h0009, 16'h0009);
        repeat (4) begin @(posedge CLK); #1; end
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        chk("rst_ready", in_ready, 1);
        push_lit("acc_cleared", 16'h0000, 0, 1);
        issue(ADD, 1, 0, 1, 16'h0000, 16'h0000);
        drain_lits();
        repeat (20) begin @(posedge CLK); #1; end

        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            op = 3'($urandom_range(0, 7));
            use_acc = $urandom_range(0, 1);
            wb = $urandom_range(0, 1);
            acc_sel = A_W'($urandom_range(0, N - 1));
            X = rv();
            Y = rv();
            @(posedge CLK); #1;
        end
        in_valid = 0; RST = 0;
        repeat (20) begin @(posedge CLK); #1; end

        in_valid8 = 1; op8 = ADD; X8 = 8'hFF; Y8 = 8'h01;
        @(posedge CLK); #1;
        in_valid8 = 0;
        @(negedge CLK);
        chk("w8_add_valid", out_valid8, 1);
        chk("w8_add_res", Results8, 8'h00);
        chk("w8_add_cf", CF8, 1);
        @(posedge CLK); #1;
        in_valid8 = 1; op8 = MUL; X8 = 8'h10; Y8 = 8'h10;
        @(posedge CLK); #1;
        in_valid8 = 0;
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (out_valid8 === 1'b1) begin k = i; break; end
        end
        chk("w8_mul_latency", k, 9);
        chk("w8_mul_res", Results8, 8'h00);
        chk("w8_mul_cf", CF8, 1);
        chk("w8_mul_zf", ZF8, 1);

        @(posedge CLK); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
